wb_pipe_stage: RTL and testbench

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_stage.sv | 210 +++++++++++++++++++++
 tb/tb_wb_pipe_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_stage.sv
// -----------------------------------------------------------------------------
// wb_pipe_stage
// MEM/WB pipeline register and write-back result selection.
// The M-stage result sources are captured once per cycle. The written-back
// value is formed combinationally from the captured state:
//   - ALU result
//   - memory read data, optionally narrowed and extended
//   - link value (pcPlus4)
//
// Optional feature macro: WB_LOAD_EXT_EN
//   defined   : memory results get byte/half/word lane extraction and
//               sign/zero extension, steered by loadSizeM/loadUnsignedM.
//   undefined : memory result is readData as read; load size/sign are ignored.
//
// Parameters
//   WIDTH  datapath width (32 or 64)
//   RA_W   register-file address width
//
// Ports
//   clk            in   stage clock, rising edge
//   reset          in   asynchronous active-high reset
//   stallW         in   hold MEM/WB contents
//   flushW         in   load a bubble (wins over stallW)
//   validM         in   M-stage instruction valid
//   regWriteM      in   instruction writes the register file
//   resultSrcM     in   00 ALU, 01 memory, 10 link, 11 treated as ALU
//   loadSizeM      in   00 byte, 01 half, 10 word, 11 full width
//   loadUnsignedM  in   zero-extend instead of sign-extend
//   writeRegM      in   destination register
//   ALUOutM        in   ALU result (low bits also give the load lane)
//   readDataM      in   memory read word
//   pcPlus4M       in   link value
//   resultW        out  value written back
//   writeRegW      out  registered destination
//   regWriteW      out  qualified register-file write enable
//   validW         out  W-stage instruction valid
//   retireCountW   out  count of retired valid instructions (wraps)
// -----------------------------------------------------------------------------
module wb_pipe_stage #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallW,
  input  logic             flushW,
  input  logic             validM,
  input  logic             regWriteM,
  input  logic [1:0]       resultSrcM,
  input  logic [1:0]       loadSizeM,
  input  logic             loadUnsignedM,
  input  logic [RA_W-1:0]  writeRegM,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [WIDTH-1:0] readDataM,
  input  logic [WIDTH-1:0] pcPlus4M,
  output logic [WIDTH-1:0] resultW,
  output logic [RA_W-1:0]  writeRegW,
  output logic             regWriteW,
  output logic             validW,
  output logic [31:0]      retireCountW
);

  // MEM/WB register state
  logic             validR;
  logic             regWriteR;     // already qualified by valid and rd != 0
  logic [1:0]       resultSrcR;
  logic [RA_W-1:0]  writeRegR;
  logic [WIDTH-1:0] aluOutR;
  logic [WIDTH-1:0] readDataR;
  logic [WIDTH-1:0] pcPlus4R;
  logic [31:0]      retireCountR;

  logic [WIDTH-1:0] memDataS;
  logic [WIDTH-1:0] resultS;

  // A load to r0 or an invalid slot never reaches the register file, so the
  // enable is qualified before it is stored and the output is a plain flop.
  logic             regWriteQualS;
  assign regWriteQualS = validM & regWriteM & (writeRegM != '0);

`ifdef WB_LOAD_EXT_EN
  localparam int OFF_W = $clog2(WIDTH / 8);
  // Offset masks that align a byte address down to a half / word boundary.
  localparam logic [OFF_W-1:0] HALF_MASK = ~(OFF_W'(2'd1));
  localparam logic [OFF_W-1:0] WORD_MASK = ~(OFF_W'(2'd3));

  logic [1:0]       loadSizeR;
  logic             loadUnsignedR;
  logic [OFF_W-1:0] alignOffS;
  logic [7:0]       fieldBitsS;
  logic [WIDTH-1:0] shiftedS;

  // Extend the low fieldBits of raw to WIDTH: shift the field to the top,
  // then shift back logically (zero-extend) or arithmetically (sign-extend).
  function automatic logic [WIDTH-1:0] extendField(
    input logic [WIDTH-1:0] raw,
    input logic [7:0]       fieldBits,
    input logic             zeroExt
  );
    logic [7:0]       pad;
    logic [WIDTH-1:0] up;
    pad = 8'(WIDTH) - fieldBits;
    up  = raw << pad;
    if (zeroExt) begin
      return up >> pad;
    end else begin
      return $signed(up) >>> pad;
    end
  endfunction

  // Load lane selection and extension of the captured read word
  always_comb begin
    alignOffS  = aluOutR[OFF_W-1:0];
    fieldBitsS = 8'(WIDTH);
    case (loadSizeR)
      2'b00: begin
        alignOffS  = aluOutR[OFF_W-1:0];
        fieldBitsS = 8'd8;
      end
      2'b01: begin
        alignOffS  = aluOutR[OFF_W-1:0] & HALF_MASK;
        fieldBitsS = 8'd16;
      end
      2'b10: begin
        // For WIDTH=32 the mask is zero and this degenerates to full width.
        alignOffS  = aluOutR[OFF_W-1:0] & WORD_MASK;
        fieldBitsS = 8'd32;
      end
      2'b11: begin
        alignOffS  = '0;
        fieldBitsS = 8'(WIDTH);
      end
      default: begin
        alignOffS  = '0;
        fieldBitsS = 8'(WIDTH);
      end
    endcase
    shiftedS = readDataR >> {alignOffS, 3'b000};
    memDataS = extendField(shiftedS, fieldBitsS, loadUnsignedR);
  end
`else
  // Load size/sign only steer the extraction path, which is not built here.
  logic unusedLoadCtl;
  assign unusedLoadCtl = ^{loadSizeM, loadUnsignedM};

  // Memory result is the read word as delivered
  always_comb begin
    memDataS = readDataR;
  end
`endif

  // MEM/WB register: flush beats stall, stall holds, otherwise capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validR        <= 1'b0;
      regWriteR     <= 1'b0;
      resultSrcR    <= 2'b00;
      writeRegR     <= '0;
      aluOutR       <= '0;
      readDataR     <= '0;
      pcPlus4R      <= '0;
      retireCountR  <= 32'd0;
`ifdef WB_LOAD_EXT_EN
      loadSizeR     <= 2'b00;
      loadUnsignedR <= 1'b0;
`endif
    end else if (flushW) begin
      // Bubble: the slot carries no instruction and writes nothing.
      validR    <= 1'b0;
      regWriteR <= 1'b0;
    end else if (stallW) begin
      validR    <= validR;
      regWriteR <= regWriteR;
    end else begin
      validR        <= validM;
      regWriteR     <= regWriteQualS;
      resultSrcR    <= resultSrcM;
      writeRegR     <= writeRegM;
      aluOutR       <= ALUOutM;
      readDataR     <= readDataM;
      pcPlus4R      <= pcPlus4M;
`ifdef WB_LOAD_EXT_EN
      loadSizeR     <= loadSizeM;
      loadUnsignedR <= loadUnsignedM;
`endif
      if (validM) begin
        retireCountR <= retireCountR + 32'd1;
      end else begin
        retireCountR <= retireCountR;
      end
    end
  end

  // Write-back source select; the reserved encoding falls back to the ALU
  always_comb begin
    case (resultSrcR)
      2'b00:   resultS = aluOutR;
      2'b01:   resultS = memDataS;
      2'b10:   resultS = pcPlus4R;
      default: resultS = aluOutR;
    endcase
  end

  assign resultW      = resultS;
  assign writeRegW    = writeRegR;
  assign regWriteW    = regWriteR;
  assign validW       = validR;
  assign retireCountW = retireCountR;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_pipe_stage
// Directed bench for wb_pipe_stage (WIDTH=32, RA_W=5). Each step drives one
// M-stage instruction, pushes the expected W-stage view to a scoreboard queue,
// and pops/compares it at the following falling edge. Expectations for
// memory loads depend on whether WB_LOAD_EXT_EN is defined.
// -----------------------------------------------------------------------------
module tb_wb_pipe_stage;

  logic        clk;
  logic        reset;
  logic        stallW;
  logic        flushW;
  logic        validM;
  logic        regWriteM;
  logic [1:0]  resultSrcM;
  logic [1:0]  loadSizeM;
  logic        loadUnsignedM;
  logic [4:0]  writeRegM;
  logic [31:0] ALUOutM;
  logic [31:0] readDataM;
  logic [31:0] pcPlus4M;
  logic [31:0] resultW;
  logic [4:0]  writeRegW;
  logic        regWriteW;
  logic        validW;
  logic [31:0] retireCountW;

  wb_pipe_stage #(.WIDTH(32), .RA_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .stallW        (stallW),
    .flushW        (flushW),
    .validM        (validM),
    .regWriteM     (regWriteM),
    .resultSrcM    (resultSrcM),
    .loadSizeM     (loadSizeM),
    .loadUnsignedM (loadUnsignedM),
    .writeRegM     (writeRegM),
    .ALUOutM       (ALUOutM),
    .readDataM     (readDataM),
    .pcPlus4M      (pcPlus4M),
    .resultW       (resultW),
    .writeRegW     (writeRegW),
    .regWriteW     (regWriteW),
    .validW        (validW),
    .retireCountW  (retireCountW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic        chkResult;
    logic [4:0]  writeReg;
    logic        chkWriteReg;
    logic        regWrite;
    logic        valid;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];

  int nChecks = 0;
  int nFails  = 0;

  // Reference state of the W stage
  logic        mValid;
  logic        mRegWrite;
  logic [31:0] mResult;
  logic        mResultKnown;
  logic [4:0]  mWriteReg;
  logic [31:0] mCount;

  localparam logic [31:0] LOADWORD = 32'h80FF7F01;

  function automatic logic [31:0] memExp(input logic [31:0] extended, input logic [31:0] raw);
`ifdef WB_LOAD_EXT_EN
    return extended;
`else
    return raw;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nFails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic modelReset();
    mValid       = 1'b0;
    mRegWrite    = 1'b0;
    mResult      = 32'd0;
    mResultKnown = 1'b1;
    mWriteReg    = 5'd0;
    mCount       = 32'd0;
  endtask

  task automatic checkAll(input string tag);
    if (mResultKnown) chk({tag, ".result"}, resultW, mResult);
    chk({tag, ".writeReg"}, {27'd0, writeRegW}, {27'd0, mWriteReg});
    chk({tag, ".regWrite"}, {31'd0, regWriteW}, {31'd0, mRegWrite});
    chk({tag, ".valid"}, {31'd0, validW}, {31'd0, mValid});
    chk({tag, ".count"}, retireCountW, mCount);
  endtask

  // Called right after a falling edge: drive, predict, clock, compare.
  task automatic step(input string tag, input logic vM, input logic rwM,
                      input logic [1:0] src, input logic [1:0] sz, input logic uns,
                      input logic [4:0] wr, input logic [31:0] alu, input logic [31:0] rd,
                      input logic [31:0] pc, input logic stall, input logic flush,
                      input logic [31:0] expResult);
    exp_t e;
    validM = vM; regWriteM = rwM; resultSrcM = src; loadSizeM = sz;
    loadUnsignedM = uns; writeRegM = wr; ALUOutM = alu; readDataM = rd;
    pcPlus4M = pc; stallW = stall; flushW = flush;
    if (flush) begin
      mValid = 1'b0; mRegWrite = 1'b0; mResultKnown = 1'b0;
    end else if (!stall) begin
      mValid = vM; mRegWrite = vM & rwM & (wr != 5'd0);
      mResult = expResult; mResultKnown = 1'b1; mWriteReg = wr;
      if (vM) mCount = mCount + 32'd1;
    end
    e.tag = tag; e.result = mResult; e.chkResult = mResultKnown;
    e.writeReg = mWriteReg; e.chkWriteReg = !flush;
    e.regWrite = mRegWrite; e.valid = mValid; e.count = mCount;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chkResult) chk({e.tag, ".result"}, resultW, e.result);
    if (e.chkWriteReg) chk({e.tag, ".writeReg"}, {27'd0, writeRegW}, {27'd0, e.writeReg});
    chk({e.tag, ".regWrite"}, {31'd0, regWriteW}, {31'd0, e.regWrite});
    chk({e.tag, ".valid"}, {31'd0, validW}, {31'd0, e.valid});
    chk({e.tag, ".count"}, retireCountW, e.count);
  endtask

  initial begin
    reset = 1'b1; stallW = 1'b0; flushW = 1'b0; validM = 1'b0; regWriteM = 1'b0;
    resultSrcM = 2'b00; loadSizeM = 2'b00; loadUnsignedM = 1'b0; writeRegM = 5'd0;
    ALUOutM = 32'd0; readDataM = 32'd0; pcPlus4M = 32'd0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkAll("reset");
    reset = 1'b0;

    //    tag        vM    rwM   src    sz     uns   wr     alu           rd        pc           stl   fl    expected
    step("alu",      1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd8,  32'h0000_1234, 32'd0,   32'd0,       1'b0, 1'b0, 32'h0000_1234);
    step("ldbS2",    1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 5'd9,  32'h0000_1002, LOADWORD, 32'd0,      1'b0, 1'b0, memExp(32'hFFFF_FFFF, LOADWORD));
    step("ldbU2",    1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 5'd9,  32'h0000_1002, LOADWORD, 32'd0,      1'b0, 1'b0, memExp(32'h0000_00FF, LOADWORD));
    step("ldbS1",    1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 5'd10, 32'h0000_1001, LOADWORD, 32'd0,      1'b0, 1'b0, memExp(32'h0000_007F, LOADWORD));
    step("ldbS3",    1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 5'd10, 32'h0000_1003, LOADWORD, 32'd0,      1'b0, 1'b0, memExp(32'hFFFF_FF80, LOADWORD));
    step("ldhS2",    1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 5'd11, 32'h0000_1002, LOADWORD, 32'd0,      1'b0, 1'b0, memExp(32'hFFFF_80FF, LOADWORD));
    step("ldhU2",    1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 5'd11, 32'h0000_1003, LOADWORD, 32'd0,      1'b0, 1'b0, memExp(32'h0000_80FF, LOADWORD));
    step("ldhS0",    1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 5'd11, 32'h0000_1000, LOADWORD, 32'd0,      1'b0, 1'b0, memExp(32'h0000_7F01, LOADWORD));
    step("ldw",      1'b1, 1'b1, 2'b01, 2'b10, 1'b0, 5'd12, 32'h0000_1002, LOADWORD, 32'd0,      1'b0, 1'b0, LOADWORD);
    step("ldfull",   1'b1, 1'b1, 2'b01, 2'b11, 1'b1, 5'd12, 32'h0000_1001, LOADWORD, 32'd0,      1'b0, 1'b0, LOADWORD);
    step("link",     1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 5'd1,  32'h0000_5555, 32'd0,   32'h0000_0404, 1'b0, 1'b0, 32'h0000_0404);
    step("rsvdSrc",  1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 5'd2,  32'hCAFE_0001, 32'd7,   32'h0000_0408, 1'b0, 1'b0, 32'hCAFE_0001);
    step("r0write",  1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd0,  32'h0000_0077, 32'd0,   32'd0,       1'b0, 1'b0, 32'h0000_0077);
    step("noWrite",  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 5'd5,  32'h0000_0088, 32'd0,   32'd0,       1'b0, 1'b0, 32'h0000_0088);
    step("invalid",  1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd5,  32'h0000_0099, 32'd0,   32'd0,       1'b0, 1'b0, 32'h0000_0099);
    step("preStall", 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd6,  32'h0000_AAAA, 32'd0,   32'd0,       1'b0, 1'b0, 32'h0000_AAAA);
    step("stall",    1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd7,  32'h0000_BBBB, 32'd0,   32'd0,       1'b1, 1'b0, 32'h0000_BBBB);
    step("stallFl",  1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd7,  32'h0000_CCCC, 32'd0,   32'd0,       1'b1, 1'b1, 32'h0000_CCCC);
    step("flush",    1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd7,  32'h0000_DDDD, 32'd0,   32'd0,       1'b0, 1'b1, 32'h0000_DDDD);
    step("afterFl",  1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd3,  32'h0000_0101, 32'd0,   32'd0,       1'b0, 1'b0, 32'h0000_0101);

    // Counter wrap: preset the count to all ones, then retire one instruction.
    force dut.retireCountR = 32'hFFFF_FFFF;
    #1;
    release dut.retireCountR;
    mCount = 32'hFFFF_FFFF;
    chk("preset.count", retireCountW, mCount);
    #1;
    step("wrap",     1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd4,  32'h0000_0202, 32'd0,   32'd0,       1'b0, 1'b0, 32'h0000_0202);

    // Reset mid-cycle while stalled and flushed: outputs clear before the next edge.
    validM = 1'b1; regWriteM = 1'b1; writeRegM = 5'd9; ALUOutM = 32'h0000_3333;
    stallW = 1'b1; flushW = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("midReset");
    @(posedge clk);
    @(negedge clk);
    checkAll("heldReset");
    reset = 1'b0;
    step("postReset", 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 5'd8, 32'h0000_1234, 32'd0,   32'd0,       1'b0, 1'b0, 32'h0000_1234);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
